// File: rtl/collision_response.sv
// collision_response
// Per-frame collision consumer for the player car. Pixel-rate collision flags
// are latched across a video frame and, at each frame boundary, a player-status
// state machine advances: health and fuel are maintained and crash / skid /
// invulnerability status is produced for the motion, drawing and sound blocks.
//
// Ports
//   clk                    system clock
//   resetN                 asynchronous active-low reset
//   startOfFrame           one-cycle pulse at frame start
//   car_collision          hit a car, boar or road edge (level, pixel rate)
//   truck_collision        hit a truck (always accompanied by car_collision)
//   oil_collision          on an oil slick
//   fuel_symbol_collision  touching the fuel symbol
//   health [2:0]           remaining health
//   fuel [7:0]             remaining fuel
//   healthOver             health is 0
//   fuelOver               fuel is 0
//   crashActive            state is CRASH (motion frozen)
//   skidActive             state is SKID (steering overridden)
//   invulnerable           state is CRASH or GRACE
//   blink                  GRACE: frame-counter bit 2, otherwise 1
//   crashPulse             one-cycle pulse on CRASH entry
//   fuelPickup             one-cycle pulse when a pickup is credited
module collision_response #(
    parameter int unsigned HEALTH_MAX        = 5,
    parameter int unsigned FUEL_MAX          = 200,
    parameter int unsigned FUEL_BONUS        = 50,
    parameter int unsigned FUEL_DRAIN_FRAMES = 30,
    parameter int unsigned CRASH_FRAMES      = 60,
    parameter int unsigned SKID_FRAMES       = 40,
    parameter int unsigned GRACE_FRAMES      = 90
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       car_collision,
    input  logic       truck_collision,
    input  logic       oil_collision,
    input  logic       fuel_symbol_collision,
    output logic [2:0] health,
    output logic [7:0] fuel,
    output logic       healthOver,
    output logic       fuelOver,
    output logic       crashActive,
    output logic       skidActive,
    output logic       invulnerable,
    output logic       blink,
    output logic       crashPulse,
    output logic       fuelPickup
);

    typedef enum logic [2:0] {
        ST_NORMAL = 3'd0,
        ST_SKID   = 3'd1,
        ST_CRASH  = 3'd2,
        ST_GRACE  = 3'd3,
        ST_DEAD   = 3'd4
    } state_t;

    localparam logic [2:0] HEALTH_INIT = 3'(HEALTH_MAX);
    localparam logic [7:0] FUEL_CAP    = 8'(FUEL_MAX);
    localparam logic [8:0] BONUS9      = 9'(FUEL_BONUS);
    localparam logic [7:0] DRAIN_LAST  = 8'(FUEL_DRAIN_FRAMES - 1);
    localparam logic [6:0] CRASH_LAST  = 7'(CRASH_FRAMES - 1);
    localparam logic [6:0] SKID_LAST   = 7'(SKID_FRAMES - 1);
    localparam logic [6:0] GRACE_LAST  = 7'(GRACE_FRAMES - 1);

    // Health decrement that saturates at zero.
    function automatic logic [2:0] health_sub(input logic [2:0] h, input logic [2:0] d);
        logic [2:0] r;
        if (h > d) begin
            r = h - d;
        end else begin
            r = 3'd0;
        end
        return r;
    endfunction

    // Fuel bonus credit, clipped to the ceiling; computed 9 bits wide so the
    // sum cannot wrap before the comparison.
    function automatic logic [7:0] fuel_add_sat(input logic [7:0] f);
        logic [8:0] s;
        logic [7:0] r;
        s = {1'b0, f} + BONUS9;
        if (s > {1'b0, FUEL_CAP}) begin
            r = FUEL_CAP;
        end else begin
            r = s[7:0];
        end
        return r;
    endfunction

    state_t     state_r, state_s;
    logic [6:0] fcnt_r, fcnt_s;
    logic [7:0] drain_r, drain_s;
    logic [2:0] health_r, health_s;
    logic [7:0] fuel_r, fuel_s, fuel_cap_s;
    logic       car_l_r, truck_l_r, oil_l_r, fuel_l_r;
    logic       crash_pulse_s, pickup_s, drain_hit_s;
    logic       health_over_r, fuel_over_r, crash_active_r, skid_active_r;
    logic       invulnerable_r, blink_r, crash_pulse_r, fuel_pickup_r;

    // Sticky per-frame collision latches; the frame-start cycle reloads them
    // so a flag seen on that cycle belongs to the new frame.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            car_l_r   <= 1'b0;
            truck_l_r <= 1'b0;
            oil_l_r   <= 1'b0;
            fuel_l_r  <= 1'b0;
        end else if (startOfFrame) begin
            car_l_r   <= car_collision;
            truck_l_r <= truck_collision;
            oil_l_r   <= oil_collision;
            fuel_l_r  <= fuel_symbol_collision;
        end else begin
            car_l_r   <= car_l_r   | car_collision;
            truck_l_r <= truck_l_r | truck_collision;
            oil_l_r   <= oil_l_r   | oil_collision;
            fuel_l_r  <= fuel_l_r  | fuel_symbol_collision;
        end
    end

    // Next-state, counter, health and fuel computation.
    always_comb begin
        state_s       = state_r;
        fcnt_s        = fcnt_r;
        drain_s       = drain_r;
        health_s      = health_r;
        fuel_s        = fuel_r;
        fuel_cap_s    = fuel_r;
        crash_pulse_s = 1'b0;
        pickup_s      = 1'b0;
        drain_hit_s   = 1'b0;
        if (state_r == ST_DEAD) begin
            state_s = ST_DEAD;
        end else if ((health_r == 3'd0) || (fuel_r == 8'd0)) begin
            // Death is taken on the cycle after a register reaches zero,
            // regardless of frame timing.
            state_s = ST_DEAD;
        end else if (startOfFrame) begin
            case (state_r)
                ST_NORMAL, ST_SKID: begin
                    // Truck wins over car so a combined hit costs 2, not 3.
                    if (truck_l_r) begin
                        health_s = health_sub(health_r, 3'd2);
                        state_s  = ST_CRASH;
                    end else if (car_l_r) begin
                        health_s = health_sub(health_r, 3'd1);
                        state_s  = ST_CRASH;
                    end else if (oil_l_r && (state_r == ST_NORMAL)) begin
                        state_s = ST_SKID;
                    end else if ((state_r == ST_SKID) && (fcnt_r == SKID_LAST)) begin
                        state_s = ST_NORMAL;
                    end else begin
                        state_s = state_r;
                    end
                    // Drain only advances while the car is driveable.
                    if (drain_r == DRAIN_LAST) begin
                        drain_s     = 8'd0;
                        drain_hit_s = 1'b1;
                    end else begin
                        drain_s = drain_r + 8'd1;
                    end
                end
                ST_CRASH: begin
                    if (fcnt_r == CRASH_LAST) begin
                        state_s = ST_GRACE;
                    end else begin
                        state_s = ST_CRASH;
                    end
                end
                ST_GRACE: begin
                    if (fcnt_r == GRACE_LAST) begin
                        state_s = ST_NORMAL;
                    end else begin
                        state_s = ST_GRACE;
                    end
                end
                default: begin
                    state_s = ST_NORMAL;
                end
            endcase
            if (fuel_l_r) begin
                pickup_s   = 1'b1;
                fuel_cap_s = fuel_add_sat(fuel_r);
            end else begin
                fuel_cap_s = fuel_r;
            end
            // Drain applies after the pickup has been clipped to the ceiling.
            if (drain_hit_s && (fuel_cap_s != 8'd0)) begin
                fuel_s = fuel_cap_s - 8'd1;
            end else begin
                fuel_s = fuel_cap_s;
            end
            if (state_s != state_r) begin
                fcnt_s = 7'd0;
            end else begin
                fcnt_s = fcnt_r + 7'd1;
            end
            crash_pulse_s = (state_s == ST_CRASH) && (state_r != ST_CRASH);
        end else begin
            state_s = state_r;
        end
    end

    // State, counters, health and fuel registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_r  <= ST_NORMAL;
            fcnt_r   <= 7'd0;
            drain_r  <= 8'd0;
            health_r <= HEALTH_INIT;
            fuel_r   <= FUEL_CAP;
        end else begin
            state_r  <= state_s;
            fcnt_r   <= fcnt_s;
            drain_r  <= drain_s;
            health_r <= health_s;
            fuel_r   <= fuel_s;
        end
    end

    // Status outputs registered from the next-state values so they line up
    // with the state/health/fuel registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            health_over_r  <= 1'b0;
            fuel_over_r    <= 1'b0;
            crash_active_r <= 1'b0;
            skid_active_r  <= 1'b0;
            invulnerable_r <= 1'b0;
            blink_r        <= 1'b1;
            crash_pulse_r  <= 1'b0;
            fuel_pickup_r  <= 1'b0;
        end else begin
            health_over_r  <= (health_s == 3'd0);
            fuel_over_r    <= (fuel_s == 8'd0);
            crash_active_r <= (state_s == ST_CRASH);
            skid_active_r  <= (state_s == ST_SKID);
            invulnerable_r <= (state_s == ST_CRASH) || (state_s == ST_GRACE);
            blink_r        <= (state_s == ST_GRACE) ? fcnt_s[2] : 1'b1;
            crash_pulse_r  <= crash_pulse_s;
            fuel_pickup_r  <= pickup_s;
        end
    end

    assign health       = health_r;
    assign fuel         = fuel_r;
    assign healthOver   = health_over_r;
    assign fuelOver     = fuel_over_r;
    assign crashActive  = crash_active_r;
    assign skidActive   = skid_active_r;
    assign invulnerable = invulnerable_r;
    assign blink        = blink_r;
    assign crashPulse   = crash_pulse_r;
    assign fuelPickup   = fuel_pickup_r;

endmodule

// File: tb/tb_collision_response.sv
module tb_collision_response;

    localparam int FL = 8;   // cycles per ordinary frame

    logic       clk = 1'b0;
    logic       resetN, startOfFrame, car_collision, truck_collision;
    logic       oil_collision, fuel_symbol_collision;
    logic [2:0] health;
    logic [7:0] fuel;
    logic       healthOver, fuelOver, crashActive, skidActive;
    logic       invulnerable, blink, crashPulse, fuelPickup;

    collision_response dut (
        .clk                   (clk),
        .resetN                (resetN),
        .startOfFrame          (startOfFrame),
        .car_collision         (car_collision),
        .truck_collision       (truck_collision),
        .oil_collision         (oil_collision),
        .fuel_symbol_collision (fuel_symbol_collision),
        .health                (health),
        .fuel                  (fuel),
        .healthOver            (healthOver),
        .fuelOver              (fuelOver),
        .crashActive           (crashActive),
        .skidActive            (skidActive),
        .invulnerable          (invulnerable),
        .blink                 (blink),
        .crashPulse            (crashPulse),
        .fuelPickup            (fuelPickup)
    );

    always #5 clk = ~clk;

    logic [18:0] obs;
    assign obs = {health, fuel, healthOver, fuelOver, crashActive, skidActive,
                  invulnerable, blink, crashPulse, fuelPickup};

    int errors = 0;
    int checks = 0;

    // Frame-level reference model. States: 0 NORMAL 1 SKID 2 CRASH 3 GRACE 4 DEAD
    int m_st, m_h, m_f, m_fc, m_dc;
    bit lc, lt, lo, lf;
    logic [18:0] sb_q[$];
    bit cp_last, fp_last;

    task automatic model_reset();
        m_st = 0; m_h = 5; m_f = 200; m_fc = 0; m_dc = 0;
        lc = 0; lt = 0; lo = 0; lf = 0;
        sb_q.delete();
    endtask

    // Frame boundary: consume the latched flags and push the expected outputs.
    task automatic model_sof(input bit sof_car);
        int prev;
        bit drain, pick, cp, bl;
        drain = 0; pick = 0; cp = 0;
        prev = m_st;
        if (m_st != 4) begin
            pick = lf;
            if (prev == 0 || prev == 1) begin
                if (lt) begin m_h = (m_h >= 2) ? m_h - 2 : 0; m_st = 2; end
                else if (lc) begin m_h = (m_h >= 1) ? m_h - 1 : 0; m_st = 2; end
                else if (lo && prev == 0) m_st = 1;
                else if (prev == 1 && m_fc == 39) m_st = 0;
                m_dc = m_dc + 1;
                if (m_dc == 30) begin m_dc = 0; drain = 1; end
            end else if (prev == 2) begin
                if (m_fc == 59) m_st = 3;
            end else if (prev == 3) begin
                if (m_fc == 89) m_st = 0;
            end
            if (pick) m_f = (m_f + 50 > 200) ? 200 : m_f + 50;
            if (drain && m_f > 0) m_f = m_f - 1;
            m_fc = (m_st != prev) ? 0 : (m_fc + 1) % 128;
            cp = (m_st == 2) && (prev != 2);
        end
        bl = (m_st == 3) ? ((m_fc & 4) != 0) : 1'b1;
        sb_q.push_back({3'(m_h), 8'(m_f), m_h == 0, m_f == 0, m_st == 2, m_st == 1,
                        (m_st == 2) || (m_st == 3), bl, cp, pick});
        if (m_st != 4 && (m_h == 0 || m_f == 0)) m_st = 4;
        lc = sof_car; lt = 0; lo = 0; lf = 0;
    endtask

    // One frame: pulse, then flags held for 'hold' cycles; the scoreboard is
    // popped right after the pulse edge.
    task automatic run_frame(input int len, input bit c, input bit t, input bit o,
                             input bit fs, input int hold, input bit sc);
        logic [18:0] e;
        startOfFrame = 1'b1; car_collision = sc; truck_collision = 1'b0;
        oil_collision = 1'b0; fuel_symbol_collision = 1'b0;
        model_sof(sc);
        @(posedge clk); #1;
        startOfFrame = 1'b0;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got no entry, required one");
        end else begin
            e = sb_q.pop_front();
            if (obs !== e) begin
                errors++;
                $display("FAIL frame_out: got %h required %h", obs, e);
            end
        end
        cp_last = crashPulse; fp_last = fuelPickup;
        for (int i = 1; i < len; i++) begin
            car_collision         = (i <= hold) ? c : 1'b0;
            truck_collision       = (i <= hold) ? t : 1'b0;
            oil_collision         = (i <= hold) ? o : 1'b0;
            fuel_symbol_collision = (i <= hold) ? fs : 1'b0;
            if (i <= hold) begin lc |= c; lt |= t; lo |= o; lf |= fs; end
            @(posedge clk); #1;
            if (i == 1) begin
                checks++;
                if ({crashPulse, fuelPickup} !== 2'b00) begin
                    errors++;
                    $display("FAIL pulse_width: got %b required 00", {crashPulse, fuelPickup});
                end
                if (m_st == 4) begin
                    checks++;
                    if ({crashActive, skidActive, invulnerable, blink} !== 4'b0001) begin
                        errors++;
                        $display("FAIL dead_status: got %b required 0001",
                                 {crashActive, skidActive, invulnerable, blink});
                    end
                end
            end
        end
        car_collision = 1'b0; truck_collision = 1'b0;
        oil_collision = 1'b0; fuel_symbol_collision = 1'b0;
    endtask

    task automatic frame(input bit c, input bit t, input bit o, input bit fs);
        run_frame(FL, c, t, o, fs, FL - 1, 1'b0);
    endtask

    task automatic do_reset();
        startOfFrame = 1'b0; car_collision = 1'b0; truck_collision = 1'b0;
        oil_collision = 1'b0; fuel_symbol_collision = 1'b0;
        resetN = 1'b0;
        #3;
        model_reset();
        @(negedge clk); resetN = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        startOfFrame = 1'b0; car_collision = 1'b1; truck_collision = 1'b1;
        oil_collision = 1'b1; fuel_symbol_collision = 1'b1;
        resetN = 1'b0;
        #12;
        checks++;
        if (obs !== {3'd5, 8'd200, 8'b0000_0100}) begin
            errors++;
            $display("FAIL reset_values: got %h required %h", obs, {3'd5, 8'd200, 8'b0000_0100});
        end
        do_reset();
        frame(0, 0, 0, 0);
        checks++;
        if (crashActive !== 1'b0 || skidActive !== 1'b0) begin
            errors++;
            $display("FAIL reset_latches: got crash=%b skid=%b required 0 0", crashActive, skidActive);
        end
    endtask

    task automatic test_idle();
        do_reset();
        repeat (31) frame(0, 0, 0, 0);
        checks++;
        if ({health, fuel, fuelOver, crashActive, skidActive} !== {3'd5, 8'd199, 3'b000}) begin
            errors++;
            $display("FAIL idle_drain: got h=%0d f=%0d fo=%b c=%b s=%b required 5 199 0 0 0",
                     health, fuel, fuelOver, crashActive, skidActive);
        end
    endtask

    task automatic test_car();
        int n_cp, n_crash, n_grace, n_blink_low;
        do_reset();
        run_frame(510, 1, 0, 0, 0, 500, 1'b0);
        n_cp = 0; n_crash = 0; n_grace = 0; n_blink_low = 0;
        for (int k = 0; k < 160; k++) begin
            frame(0, 0, 0, 0);
            n_cp += int'(cp_last);
            if (crashActive) n_crash++;
            if (invulnerable && !crashActive) n_grace++;
            if (!blink) n_blink_low++;
        end
        checks++;
        if (health !== 3'd4) begin errors++; $display("FAIL car_health: got %0d required 4", health); end
        checks++;
        if (n_cp != 1) begin errors++; $display("FAIL car_pulse_count: got %0d required 1", n_cp); end
        checks++;
        if (n_crash != 60) begin errors++; $display("FAIL crash_frames: got %0d required 60", n_crash); end
        checks++;
        if (n_grace != 90) begin errors++; $display("FAIL grace_frames: got %0d required 90", n_grace); end
        checks++;
        if (n_blink_low != 46) begin errors++; $display("FAIL blink_low_frames: got %0d required 46", n_blink_low); end
        checks++;
        if (invulnerable !== 1'b0) begin errors++; $display("FAIL back_to_normal: got inv=%b required 0", invulnerable); end
    endtask

    task automatic test_truck();
        int n;
        do_reset();
        frame(1, 1, 0, 0);
        frame(0, 0, 0, 0);
        checks++;
        if (health !== 3'd3 || crashActive !== 1'b1) begin
            errors++;
            $display("FAIL truck_health: got h=%0d c=%b required 3 1", health, crashActive);
        end
        n = 0;
        while (!(invulnerable && !crashActive) && n < 100) begin frame(0, 0, 0, 0); n++; end
        checks++;
        if (!(invulnerable && !crashActive)) begin
            errors++;
            $display("FAIL grace_timeout: got inv=%b crash=%b required 1 0", invulnerable, crashActive);
        end
        frame(1, 0, 0, 0);
        frame(0, 0, 0, 0);
        checks++;
        if (health !== 3'd3 || crashActive !== 1'b0) begin
            errors++;
            $display("FAIL grace_ignores_car: got h=%0d c=%b required 3 0", health, crashActive);
        end
    endtask

    task automatic test_oil();
        int n_skid;
        do_reset();
        frame(0, 0, 1, 0);
        n_skid = 0;
        for (int k = 1; k <= 50; k++) begin
            frame(0, 0, k == 20, 0);
            if (skidActive) n_skid++;
        end
        checks++;
        if (n_skid != 40) begin errors++; $display("FAIL skid_frames: got %0d required 40", n_skid); end
        frame(0, 0, 1, 0);
        for (int k = 1; k <= 30; k++) begin
            frame(k == 25, 0, k == 20, 0);
            if (k == 25) begin
                checks++;
                if (skidActive !== 1'b1) begin errors++; $display("FAIL skid_before_car: got %b required 1", skidActive); end
            end
            if (k == 26) begin
                checks++;
                if ({crashActive, skidActive, health} !== {2'b10, 3'd4}) begin
                    errors++;
                    $display("FAIL skid_car_crash: got c=%b s=%b h=%0d required 1 0 4",
                             crashActive, skidActive, health);
                end
            end
        end
    endtask

    task automatic test_fuel();
        int n_fp;
        do_reset();
        repeat (600) frame(0, 0, 0, 0);
        checks++;
        if (fuel !== 8'd180) begin errors++; $display("FAIL fuel_drained: got %0d required 180", fuel); end
        frame(0, 0, 0, 1);
        frame(0, 0, 0, 0);
        checks++;
        if (fuel !== 8'd200 || fp_last !== 1'b1) begin
            errors++;
            $display("FAIL fuel_pickup_sat: got f=%0d p=%b required 200 1", fuel, fp_last);
        end
        n_fp = 0;
        for (int k = 0; k < 5; k++) begin
            frame(0, 0, 0, k < 3);
            if (k > 0) n_fp += int'(fp_last);
        end
        checks++;
        if (n_fp != 3 || fuel !== 8'd200) begin
            errors++;
            $display("FAIL fuel_held_3: got pickups=%0d f=%0d required 3 200", n_fp, fuel);
        end
    endtask

    task automatic test_death();
        int n;
        do_reset();
        for (int hit = 0; hit < 2; hit++) begin
            frame(1, 1, 0, 0);
            frame(0, 0, 0, 0);
            n = 0;
            while (invulnerable && n < 200) begin frame(0, 0, 0, 0); n++; end
            checks++;
            if (invulnerable !== 1'b0) begin errors++; $display("FAIL recover_timeout: got inv=%b required 0", invulnerable); end
        end
        checks++;
        if (health !== 3'd1) begin errors++; $display("FAIL health_one: got %0d required 1", health); end
        frame(1, 0, 0, 0);
        frame(0, 0, 0, 0);
        checks++;
        if (health !== 3'd0 || healthOver !== 1'b1) begin
            errors++;
            $display("FAIL health_zero: got h=%0d ho=%b required 0 1", health, healthOver);
        end
        frame(1, 1, 1, 1);
        frame(1, 0, 0, 1);
        frame(0, 0, 1, 0);
        frame(0, 0, 0, 0);
        checks++;
        if ({health, healthOver, crashActive, invulnerable, blink, fuelPickup} !== {3'd0, 5'b10010}) begin
            errors++;
            $display("FAIL dead_frozen: got h=%0d ho=%b c=%b i=%b b=%b p=%b required 0 1 0 0 1 0",
                     health, healthOver, crashActive, invulnerable, blink, fuelPickup);
        end
        car_collision = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        resetN = 1'b0;
        #2;
        checks++;
        if ({health, fuel, healthOver, crashActive} !== {3'd5, 8'd200, 2'b00}) begin
            errors++;
            $display("FAIL async_reset: got h=%0d f=%0d ho=%b c=%b required 5 200 0 0",
                     health, fuel, healthOver, crashActive);
        end
        car_collision = 1'b0;
        model_reset();
        @(negedge clk); resetN = 1'b1;
        @(posedge clk); #1;
        frame(0, 0, 0, 0);
        frame(0, 0, 0, 0);
        checks++;
        if (crashActive !== 1'b0 || health !== 3'd5) begin
            errors++;
            $display("FAIL latch_discard: got c=%b h=%0d required 0 5", crashActive, health);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        run_frame(FL, 0, 0, 0, 0, 0, 1'b1);
        checks++;
        if (crashActive !== 1'b0) begin errors++; $display("FAIL sof_flag_early: got %b required 0", crashActive); end
        frame(0, 0, 0, 0);
        checks++;
        if (crashActive !== 1'b1 || health !== 3'd4) begin
            errors++;
            $display("FAIL sof_flag_next: got c=%b h=%0d required 1 4", crashActive, health);
        end
        do_reset();
        repeat (28) frame(0, 0, 0, 0);
        frame(0, 0, 0, 1);
        frame(0, 0, 0, 0);
        checks++;
        if (fuel !== 8'd199 || fp_last !== 1'b1) begin
            errors++;
            $display("FAIL pickup_and_drain: got f=%0d p=%b required 199 1", fuel, fp_last);
        end
    endtask

    initial begin
        resetN = 1'b0; startOfFrame = 1'b0; car_collision = 1'b0;
        truck_collision = 1'b0; oil_collision = 1'b0; fuel_symbol_collision = 1'b0;
        model_reset();
        test_reset();
        test_idle();
        test_car();
        test_truck();
        test_oil();
        test_fuel();
        test_death();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
